// File: rtl/gorev4_histogram_alici.sv
// rtl/gorev4_histogram_alici.sv - histogram receiver that builds an 8-bit equalization LUT (CDF + restoring divide)
// Optional: define GOREV4_CDF_MIN_EN to subtract the first nonzero CDF value before mapping.
module gorev4_histogram_alici (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic        veri_gonder_i,
  input  logic [31:0] veri_i,
  output logic        veri_al_o,
  output logic        islem_bitti_o,
  input  logic [7:0]  lut_adres_i,
  output logic [7:0]  lut_veri_o
);
  typedef enum logic [1:0] {TOPLA, CDF, BOL, HAZIR} state_t;

  state_t      state_q;
  logic [7:0]  bin_q;        // expected index in TOPLA, current bin in CDF and BOL
  logic [23:0] acc_q;
  logic [23:0] den_q;
  logic        zero_q;
  logic        busy_q;
  logic [4:0]  cnt_q;
  logic [31:0] quo_q;
  logic [24:0] rem_q;
  logic        veri_al_q;
  logic        islem_bitti_q;
  logic [7:0]  lut_veri_q;
`ifdef GOREV4_CDF_MIN_EN
  logic [23:0] cdf_min_q;
  logic [23:0] cdf_min_d;
`endif

  // Raw counts are overwritten in place by the running CDF.
  logic [23:0] hist_mem [256];
  logic [7:0]  lut_mem [256];

  logic        capture;
  logic [23:0] cdf_k;
  logic [24:0] sum_raw;
  logic [23:0] cdf_d;
  logic [23:0] den_d;
  logic        den_zero_d;
  logic [23:0] num_base;
  logic [31:0] num_d;
  logic [25:0] shifted;
  logic        qbit;
  logic [24:0] diff;
  logic [24:0] rem_d;
  logic [31:0] quo_d;
  logic [7:0]  lut_d;
  logic        hist_we;
  logic        lut_we;
  logic [23:0] hist_wdata;

  always_comb begin
    capture = (state_q == TOPLA) && veri_gonder_i && (veri_i[31:24] == bin_q);
    cdf_k   = hist_mem[bin_q];
    sum_raw = {1'b0, acc_q} + {1'b0, cdf_k};
    cdf_d   = sum_raw[24] ? 24'hFFFFFF : sum_raw[23:0];
`ifdef GOREV4_CDF_MIN_EN
    cdf_min_d = ((cdf_min_q == 24'd0) && (cdf_d != 24'd0)) ? cdf_d : cdf_min_q;
    den_d     = cdf_d - cdf_min_d;
    num_base  = (cdf_k >= cdf_min_q) ? (cdf_k - cdf_min_q) : 24'd0;
`else
    den_d    = cdf_d;
    num_base = cdf_k;
`endif
    den_zero_d = (den_d == 24'd0);
    num_d      = ({8'd0, num_base} << 8) - {8'd0, num_base};
    // One restoring step: shift in the next dividend bit, subtract if it fits.
    shifted = {rem_q, quo_q[31]};
    qbit    = (shifted >= {2'b00, den_q});
    diff    = shifted[24:0] - {1'b0, den_q};
    rem_d   = qbit ? diff : shifted[24:0];
    quo_d   = {quo_q[30:0], qbit};
    lut_d   = (quo_d > 32'd255) ? 8'hFF : quo_d[7:0];
    hist_we    = en_i && (capture || (state_q == CDF));
    hist_wdata = (state_q == CDF) ? cdf_d : veri_i[23:0];
    lut_we     = en_i && (state_q == BOL) && busy_q && (cnt_q == 5'd31);
  end

  always_ff @(posedge clk_i) begin
    if (hist_we) hist_mem[bin_q] <= hist_wdata;
    if (lut_we)  lut_mem[bin_q]  <= lut_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= TOPLA;
      bin_q         <= 8'd0;
      acc_q         <= 24'd0;
      den_q         <= 24'd0;
      zero_q        <= 1'b0;
      busy_q        <= 1'b0;
      cnt_q         <= 5'd0;
      quo_q         <= 32'd0;
      rem_q         <= 25'd0;
      veri_al_q     <= 1'b1;
      islem_bitti_q <= 1'b0;
      lut_veri_q    <= 8'd0;
`ifdef GOREV4_CDF_MIN_EN
      cdf_min_q     <= 24'd0;
`endif
    end else if (en_i) begin
      case (state_q)
        TOPLA: begin
          if (capture) begin
            bin_q <= bin_q + 8'd1;
            if (bin_q == 8'd255) begin
              veri_al_q <= 1'b0;
              acc_q     <= 24'd0;
              state_q   <= CDF;
`ifdef GOREV4_CDF_MIN_EN
              cdf_min_q <= 24'd0;
`endif
            end
          end
        end
        CDF: begin
          acc_q <= cdf_d;
          bin_q <= bin_q + 8'd1;
`ifdef GOREV4_CDF_MIN_EN
          cdf_min_q <= cdf_min_d;
`endif
          if (bin_q == 8'd255) begin
            den_q  <= den_d;
            zero_q <= den_zero_d;
            busy_q <= 1'b0;
            // A zero denominator skips the divider; reads then return 0.
            if (den_zero_d) begin
              state_q       <= HAZIR;
              islem_bitti_q <= 1'b1;
            end else begin
              state_q <= BOL;
            end
          end
        end
        BOL: begin
          if (!busy_q) begin
            quo_q  <= num_d;
            rem_q  <= 25'd0;
            cnt_q  <= 5'd0;
            busy_q <= 1'b1;
          end else begin
            quo_q <= quo_d;
            rem_q <= rem_d;
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
              busy_q <= 1'b0;
              bin_q  <= bin_q + 8'd1;
              if (bin_q == 8'd255) begin
                state_q       <= HAZIR;
                islem_bitti_q <= 1'b1;
              end
            end
          end
        end
        HAZIR: begin
          lut_veri_q <= zero_q ? 8'd0 : lut_mem[lut_adres_i];
        end
        default: state_q <= TOPLA;
      endcase
    end
  end

  assign veri_al_o     = veri_al_q;
  assign islem_bitti_o = islem_bitti_q;
  assign lut_veri_o    = lut_veri_q;
endmodule

// File: tb/tb_gorev4_histogram_alici.sv
// tb/tb_gorev4_histogram_alici.sv - scoreboard bench for gorev4_histogram_alici with a reference LUT model
module tb_gorev4_histogram_alici;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        en_i = 1'b1;
  logic        veri_gonder_i = 1'b0;
  logic [31:0] veri_i = 32'd0;
  logic        veri_al_o;
  logic        islem_bitti_o;
  logic [7:0]  lut_adres_i = 8'd0;
  logic [7:0]  lut_veri_o;

  gorev4_histogram_alici dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i),
    .veri_gonder_i(veri_gonder_i), .veri_i(veri_i),
    .veri_al_o(veri_al_o), .islem_bitti_o(islem_bitti_o),
    .lut_adres_i(lut_adres_i), .lut_veri_o(lut_veri_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { int addr; int exp; } rd_t;
  rd_t  sb_q[$];
  rd_t  mon_r;
  logic rd_stb = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   hist_m [256];
  int   lut_m [256];
  int   lat, dis, lat_flat;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk_i) begin
    if (rd_stb && en_i) begin
      #1;
      if (sb_q.size() == 0) chk("scoreboard underflow", 1, 0);
      else begin
        mon_r = sb_q.pop_front();
        chk($sformatf("lut[%0d]", mon_r.addr), int'(lut_veri_o), mon_r.exp);
      end
    end
  end

  task automatic build_model();
    longint c, cmin, tot, q;
    longint cd [256];
    c = 0;
    cmin = 0;
    for (int k = 0; k < 256; k++) begin
      c += hist_m[k];
      if (c > 64'hFFFFFF) c = 64'hFFFFFF;
      cd[k] = c;
      if (cmin == 0 && c != 0) cmin = c;
    end
    tot = cd[255];
    for (int k = 0; k < 256; k++) begin
`ifdef GOREV4_CDF_MIN_EN
      if (tot == cmin || cd[k] < cmin) q = 0;
      else q = (cd[k] - cmin) * 255 / (tot - cmin);
`else
      if (tot == 0) q = 0;
      else q = cd[k] * 255 / tot;
`endif
      lut_m[k] = (q > 255) ? 255 : int'(q);
    end
  endtask

  task automatic do_reset();
    @(posedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    chk("reset veri_al_o", int'(veri_al_o), 1);
    chk("reset islem_bitti_o", int'(islem_bitti_o), 0);
    chk("reset lut_veri_o", int'(lut_veri_o), 0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic send(input int idx, input int cnt, input int hold, input bit g);
    @(negedge clk_i);
    veri_gonder_i = g;
    veri_i = {8'(idx), 24'(cnt)};
    repeat (hold - 1) @(negedge clk_i);
  endtask

  // mode 0: in-order words; mode 1: 0,2,1,2,3.. order plus junk and non-valid words.
  // hold 0 picks a random hold per word. abort_at > 0 leaves the run after that many edges.
  task automatic run(input int mode, input int hold, input bit toggle, input int abort_at,
                     output int lat_o, output int dis_o);
    bit bad0;
    int h;
    for (int k = 0; k < 255; k++) begin
      h = (hold == 0) ? int'($urandom_range(1, 3)) : hold;
      if (mode == 1) begin
        if ($urandom_range(0, 3) == 0) send((k + 1 + int'($urandom_range(0, 253))) % 256, int'($urandom), 1, 1'b1);
        if ($urandom_range(0, 3) == 0) send(k, int'($urandom), 1, 1'b0);
        if (k == 1) send(2, hist_m[2] ^ 32'h5A5A5, 2, 1'b1);
      end
      send(k, hist_m[k], h, 1'b1);
    end
    @(negedge clk_i);
    veri_gonder_i = 1'b1;
    veri_i = {8'd255, 24'(hist_m[255])};
    chk("veri_al_o before last", int'(veri_al_o), 1);
    @(posedge clk_i);
    #1 chk("veri_al_o one edge after last", int'(veri_al_o), 0);
    lat_o = 0;
    dis_o = 0;
    bad0 = 1'b0;
    while (1) begin
      @(negedge clk_i);
      veri_gonder_i = 1'b0;
      if (toggle) en_i = 1'($urandom_range(0, 1));
      @(posedge clk_i);
      lat_o++;
      if (!en_i) dis_o++;
      #1;
      if (islem_bitti_o) break;
      if (lut_veri_o != 8'd0) bad0 = 1'b1;
      if (abort_at > 0 && lat_o >= abort_at) break;
      if (lat_o >= 30000) break;
    end
    en_i = 1'b1;
    if (abort_at == 0) begin
      chk("islem_bitti_o rises", int'(islem_bitti_o), 1);
      chk("latency bound", int'((lat_o - dis_o) <= 256 + 256 * 33 + 4), 1);
    end
    chk("lut_veri_o zero before done", int'(bad0), 0);
  endtask

  task automatic read_phase();
    rd_t r;
    for (int i = 0; i < 320; i++) begin
      @(negedge clk_i);
      r.addr = (i < 256) ? i : int'($urandom_range(0, 255));
      r.exp = lut_m[r.addr];
      lut_adres_i = 8'(r.addr);
      veri_gonder_i = 1'($urandom_range(0, 1));
      veri_i = $urandom;
      rd_stb = 1'b1;
      sb_q.push_back(r);
    end
    @(negedge clk_i);
    rd_stb = 1'b0;
    veri_gonder_i = 1'b0;
    for (int t = 0; t < 10 && sb_q.size() != 0; t++) @(negedge clk_i);
    chk("scoreboard drained", sb_q.size(), 0);
    chk("veri_al_o low in HAZIR", int'(veri_al_o), 0);
    chk("islem_bitti_o held", int'(islem_bitti_o), 1);
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Flat histogram, each word held 4 cycles
    for (int k = 0; k < 256; k++) hist_m[k] = 300;
    build_model();
    do_reset();
    run(0, 4, 1'b0, 0, lat_flat, dis);
    read_phase();

    // Single-bin image
    for (int k = 0; k < 256; k++) hist_m[k] = 0;
    hist_m[100] = 76800;
    build_model();
    do_reset();
    run(0, 0, 1'b0, 0, lat, dis);
    read_phase();

    // Out-of-order words with random counts (may saturate the CDF)
    for (int k = 0; k < 256; k++) hist_m[k] = int'($urandom_range(0, 32'h1FFFF));
    build_model();
    do_reset();
    run(1, 0, 1'b0, 0, lat, dis);
    read_phase();

    // All counts zero
    for (int k = 0; k < 256; k++) hist_m[k] = 0;
    build_model();
    do_reset();
    run(1, 1, 1'b0, 0, lat, dis);
    chk("zero-histogram latency", int'(lat <= 260), 1);
    read_phase();

    // Reset during bin 50 of the divide phase, then a fresh flat run
    for (int k = 0; k < 256; k++) hist_m[k] = 300;
    build_model();
    do_reset();
    run(0, 1, 1'b0, 256 + 50 * 33 + 10, lat, dis);
    chk("pre-reset veri_al_o", int'(veri_al_o), 0);
    chk("pre-reset islem_bitti_o", int'(islem_bitti_o), 0);
    do_reset();
    run(0, 4, 1'b0, 0, lat, dis);
    chk("rerun latency", lat, lat_flat);
    read_phase();

    // Random clock-enable gaps after the last word
    do_reset();
    run(0, 2, 1'b1, 0, lat, dis);
    chk("latency minus disabled cycles", lat - dis, lat_flat);
    read_phase();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/gorev4_histogram_alici.md
GOREV4_HISTOGRAM_ALICI -- requirements
Module: gorev4_histogram_alici

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high: clk_i  input  1  rising-edge clock for all state.
REQ-002 rst_i  input  1  asynchronous active-high reset.
REQ-003 en_i  input  1  clock enable; when 0 every register holds its value.
REQ-004 veri_gonder_i  input  1  sender's histogram-valid level.
REQ-005 veri_i  input  32  histogram word: [31:24] bin index, [23:0] bin count.
REQ-006 veri_al_o  output  1  high while the block collects histogram words.
REQ-007 islem_bitti_o  output  1  level, high when the equalization LUT is complete.
REQ-008 lut_adres_i  input  8  LUT read address.
REQ-009 lut_veri_o  output  8  LUT read data, registered.

Function
REQ-010 SHALL use FSM states TOPLA, CDF, BOL, HAZIR.
REQ-011 TOPLA: veri_al_o=1; expected index beklenen starts at 0.
- Capture happens on an enabled edge with veri_gonder_i=1 and veri_i[31:24]==beklenen.
- On capture: store veri_i[23:0] into hist[beklenen], then increment beklenen.
- Words with any other index, or with veri_gonder_i=0, are ignored. A held or repeated word is therefore captured once.
REQ-012 Capture of index 255 SHALL drop veri_al_o on the next edge and enter CDF.
REQ-013 CDF: one bin per enabled cycle, 256 cycles.
- cdf[k] = cdf[k-1] + hist[k], 24-bit, saturating at 0xFFFFFF.
- toplam = cdf[255].
- Then enter BOL.
REQ-014 BOL: per bin k = 0..255, compute lut[k] = floor(cdf[k]*255 / toplam).
- 32-bit product.
- Sequential restoring divider, 1 quotient bit per enabled cycle, 32 cycles per bin.
- Quotient clipped to 255.
REQ-015 Denominator 0 SHALL force every lut entry to 0 without running the divider.
REQ-016 After bin 255 is written, enter HAZIR and set islem_bitti_o=1.
REQ-017 HAZIR: lut_veri_o = lut[lut_adres_i] one enabled edge after the address is presented. Read is valid in HAZIR only.
REQ-018 HAZIR: veri_gonder_i is ignored. The block stays in HAZIR until reset.
REQ-019 Outside HAZIR, lut_veri_o SHALL hold 0.
REQ-020 en_i=0 mid-divide SHALL freeze the divider iteration counter and partial remainder; no result is lost.
REQ-021 Total latency from capture of index 255 to islem_bitti_o SHALL be at most 256 + 256*33 + 4 enabled cycles.

Reset
REQ-022 Asserting rst_i at any time, including mid-TOPLA/CDF/BOL, SHALL immediately set:
- state = TOPLA, beklenen = 0;
- veri_al_o = 1, islem_bitti_o = 0, lut_veri_o = 0;
- divider registers = 0.
REQ-023 hist/cdf/lut array contents need not be cleared. Every entry is rewritten before it is read.

Configuration
REQ-024 Macro GOREV4_CDF_MIN_EN selects the mapping formula.
- Defined: cdf_min = first nonzero cdf value found during CDF.
  - lut[k] = floor((cdf[k]-cdf_min)*255 / (toplam-cdf_min)) for cdf[k] >= cdf_min.
  - Entries with cdf[k] < cdf_min are 0.
  - toplam == cdf_min forces all entries to 0.
- Undefined: the plain formula of REQ-014 applies, and no cdf_min register is synthesized.

Verification
REQ-025 Flat histogram (every count 300, toplam 76800), each word held 4 cycles:
- each bin captured once;
- islem_bitti_o rises;
- lut[0]=0 with macro (cdf[0] equals cdf_min), 0 without (floor(300*255/76800)=0);
- lut[255]=255 with and without macro;
- lut[127]=127 without macro.
REQ-026 Single-bin image (bin 100 = 76800, rest 0):
- without macro: lut[k]=0 for k<100, 255 for k>=100;
- with macro: all entries 0.
REQ-027 Out-of-order words (index 0, 2, 1, 2, 3..255):
- index 2 is ignored the first time;
- final hist equals the in-order capture;
- veri_al_o falls exactly one edge after index 255 is captured.
REQ-028 All counts zero:
- toplam=0 and all lut entries 0;
- islem_bitti_o rises within 256+4 cycles after index 255.
REQ-029 Reset asserted mid-BOL (bin 50), then released and a new flat histogram sent:
- outputs reset asynchronously on assertion;
- the second run produces the same LUT as REQ-025.
REQ-030 en_i toggled 50% randomly during BOL:
- LUT identical to the en_i=1 run;
- islem_bitti_o delayed by exactly the number of disabled cycles.
